bk_port_slave: RTL and testbench

- Synchronous K1801 MPI bus slave implementing the 16-bit user parallel port register at 177714 (octal).
- Sits directly downstream of the CPU bus master on the shared nAD/nSYNC/nDIN/nDOUT/nWTBT/nRPLY lines.
- Decodes its address, answers read and write cycles with nRPLY, and drives a latched output port while sampling an input port.
- All bus pins are active-low; tri-state/wired-AND resolution happens at the top level via the output-enable ports.

---
 rtl/bk_port_slave.sv | 170 +++++++++++++++++
 tb/tb_bk_port_slave.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bk_port_slave.sv
// bk_port_slave: K1801 MPI bus slave for the 16-bit user parallel port register at 177714 (octal).
// Ports: CLKp/nRESETp clock and async active-low reset; nADi/nSYNCi/nDINi/nDOUTi/nWTBTi bus inputs
// (active-low); nADo/nAD_oe read data and its output enable; nRPLYo wired-AND reply (0 = assert);
// port_in external input data; port_out output latch; port_wr/port_rd one-cycle update/read pulses.
// Build option BK_PORT_READBACK_EN: reads return the output latch instead of port_in.
module bk_port_slave #(
  parameter logic [15:0] BASE_ADDR   = 16'o177714,
  parameter int          SYNC_STAGES = 2,
  parameter int          RPLY_DELAY  = 1
) (
  input  logic        CLKp,
  input  logic        nRESETp,
  input  logic [15:0] nADi,
  output logic [15:0] nADo,
  output logic        nAD_oe,
  input  logic        nSYNCi,
  input  logic        nDINi,
  input  logic        nDOUTi,
  input  logic        nWTBTi,
  output logic        nRPLYo,
  input  logic [15:0] port_in,
  output logic [15:0] port_out,
  output logic        port_wr,
  output logic        port_rd
);
  typedef enum logic [2:0] {IDLE, SKIP, SEL, RD, WR, WAIT_END} state_t;
  // The counter is loaded one short because leaving SEL already costs a cycle.
  localparam logic [2:0] CNT_INIT = (RPLY_DELAY == 0) ? 3'd0 : 3'(RPLY_DELAY - 1);
  localparam bit DUE_NOW = (RPLY_DELAY == 0);
  logic [SYNC_STAGES-1:0][19:0] pipe_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic sync_prev_q, armed_q;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic done_q, done_d, addr0_q, addr0_d, unused_wtbt_a_q, wtbt_a_d;
  logic rply_q, rply_d, oe_q, oe_d, wr_q, wr_d, rd_q, rd_d;
  logic [15:0] ado_q, ado_d, port_out_q, port_out_d, rd_data, wr_val;
  logic s_sync, s_din, s_dout, s_wtbt, sync_fall, sync_rise, match;
  logic [15:0] s_ad;
`ifdef BK_PORT_READBACK_EN
  logic unused_port_in;
  assign unused_port_in = ^port_in;
  assign rd_data = port_out_q;
`else
  assign rd_data = port_in;
`endif
  assign {s_sync, s_din, s_dout, s_wtbt, s_ad} = pipe_q[SYNC_STAGES-1];
  // A fall only counts once SYNC has been seen high after reset, so a reset released mid-cycle stays quiet.
  assign sync_fall = armed_q & sync_prev_q & ~s_sync;
  assign sync_rise = ~sync_prev_q & s_sync;
  assign match = (~s_ad[15:1] == BASE_ADDR[15:1]);
  assign wr_val = s_wtbt ? ~s_ad : addr0_q ? {~s_ad[15:8], port_out_q[7:0]} : {port_out_q[15:8], ~s_ad[7:0]};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    done_d = done_q;
    addr0_d = addr0_q;
    wtbt_a_d = unused_wtbt_a_q;
    rply_d = rply_q;
    oe_d = oe_q;
    ado_d = ado_q;
    port_out_d = port_out_q;
    wr_d = 1'b0;
    rd_d = 1'b0;
    if (sync_rise) begin
      state_d = IDLE;
      rply_d = 1'b1;
      oe_d = 1'b0;
      ado_d = '1;
    end else begin
      case (state_q)
        IDLE: if (sync_fall) begin
          addr0_d = ~s_ad[0];
          wtbt_a_d = ~s_wtbt;
          done_d = 1'b0;
          state_d = match ? SEL : SKIP;
        end
        SKIP: if (s_sync) state_d = IDLE;
        SEL: if (!s_din && !s_dout) state_d = SKIP;
        else if (!s_din) begin
          state_d = RD;
          cnt_d = CNT_INIT;
          oe_d = 1'b1;
          ado_d = ~rd_data;
          rd_d = 1'b1;
          if (DUE_NOW) begin
            rply_d = 1'b0;
            done_d = 1'b1;
          end
        end else if (!s_dout) begin
          state_d = WR;
          cnt_d = CNT_INIT;
          if (DUE_NOW) begin
            rply_d = 1'b0;
            done_d = 1'b1;
            wr_d = 1'b1;
            port_out_d = wr_val;
          end
        end
        RD: if (s_din) begin
          rply_d = 1'b1;
          state_d = WAIT_END;
        end else if (!done_q) begin
          if (cnt_q == 3'd0) begin
            rply_d = 1'b0;
            done_d = 1'b1;
          end else cnt_d = cnt_q - 3'd1;
        end
        WR: if (s_dout) begin
          rply_d = 1'b1;
          state_d = WAIT_END;
        end else if (!done_q) begin
          if (cnt_q == 3'd0) begin
            rply_d = 1'b0;
            done_d = 1'b1;
            wr_d = 1'b1;
            port_out_d = wr_val;
          end else cnt_d = cnt_q - 3'd1;
        end
        WAIT_END: begin
          oe_d = 1'b0;
          ado_d = '1;
          if (s_sync) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge CLKp or negedge nRESETp) begin
    if (!nRESETp) begin
      pipe_q <= '1;
      vld_q <= '0;
      sync_prev_q <= 1'b1;
      armed_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      addr0_q <= 1'b0;
      unused_wtbt_a_q <= 1'b0;
      rply_q <= 1'b1;
      oe_q <= 1'b0;
      ado_q <= '1;
      port_out_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      pipe_q <= {pipe_q[SYNC_STAGES-2:0], {nSYNCi, nDINi, nDOUTi, nWTBTi, nADi}};
      vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sync_prev_q <= s_sync;
      armed_q <= armed_q | (vld_q[SYNC_STAGES-1] & s_sync);
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      addr0_q <= addr0_d;
      unused_wtbt_a_q <= wtbt_a_d;
      rply_q <= rply_d;
      oe_q <= oe_d;
      ado_q <= ado_d;
      port_out_q <= port_out_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  assign nRPLYo = rply_q;
  assign nAD_oe = oe_q;
  assign nADo = ado_q;
  assign port_out = port_out_q;
  assign port_wr = wr_q;
  assign port_rd = rd_q;
endmodule

// File: tb/tb_bk_port_slave.sv
// tb_bk_port_slave: randomized scoreboard bench for bk_port_slave driving MPI bus cycles.
module tb_bk_port_slave;
  localparam int S = 2;
  localparam int D = 1;
  localparam logic [15:0] BASE = 16'o177714;
  logic CLKp = 1'b0, nRESETp = 1'b0;
  logic [15:0] nADi = '1, nADo, port_in = '0, port_out;
  logic nAD_oe, nSYNCi = 1'b1, nDINi = 1'b1, nDOUTi = 1'b1, nWTBTi = 1'b1, nRPLYo, port_wr, port_rd;
  typedef struct {bit rd; logic [15:0] v;} exp_t;
  exp_t q[$];
  exp_t me;
  logic [15:0] me_ado;
  logic [15:0] model = '0;
  int checks = 0, errors = 0;

  bk_port_slave #(.BASE_ADDR(BASE), .SYNC_STAGES(S), .RPLY_DELAY(D)) dut (
    .CLKp(CLKp), .nRESETp(nRESETp), .nADi(nADi), .nADo(nADo), .nAD_oe(nAD_oe),
    .nSYNCi(nSYNCi), .nDINi(nDINi), .nDOUTi(nDOUTi), .nWTBTi(nWTBTi), .nRPLYo(nRPLYo),
    .port_in(port_in), .port_out(port_out), .port_wr(port_wr), .port_rd(port_rd)
  );

  always #5 CLKp = ~CLKp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLKp);
    #2;
  endtask

  always @(negedge CLKp) begin
    if (nRESETp && port_wr) begin
      if (q.size() == 0) chk("port_wr with nothing expected", {31'b0, port_wr}, 0);
      else begin
        me = q.pop_front();
        chk("wr event kind", {31'b0, me.rd}, 0);
        chk("port_out after write", port_out, me.v);
      end
    end
    if (nRESETp && port_rd) begin
      if (q.size() == 0) chk("port_rd with nothing expected", {31'b0, port_rd}, 0);
      else begin
        me = q.pop_front();
        me_ado = ~me.v;
        chk("rd event kind", {31'b0, me.rd}, 1);
        chk("nADo on read entry", nADo, me_ado);
        chk("nAD_oe on read entry", nAD_oe, 1);
      end
    end
  end

  task automatic xfer(input bit wr, input bit bw, input logic [15:0] a, input logic [15:0] d);
    bit hit;
    bit any_oe;
    int n;
    logic [15:0] rv, rv_n;
    hit = (a[15:1] == BASE[15:1]);
    any_oe = 1'b0;
    nADi = ~a;
    nWTBTi = ~wr;
    tick(2);
    nSYNCi = 1'b0;
    tick(4);
    nADi = wr ? ~d : 16'hFFFF;
    nWTBTi = ~bw;
`ifdef BK_PORT_READBACK_EN
    rv = model;
`else
    rv = port_in;
`endif
    rv_n = ~rv;
    if (hit) begin
      if (wr) begin
        model = !bw ? d : a[0] ? {d[15:8], model[7:0]} : {model[15:8], d[7:0]};
        q.push_back('{1'b0, model});
      end else q.push_back('{1'b1, rv});
    end
    tick(1);
    if (wr) nDOUTi = 1'b0;
    else nDINi = 1'b0;
    n = 0;
    while (n < 20) begin
      tick(1);
      n++;
      any_oe |= nAD_oe;
      if (!nRPLYo) break;
    end
    if (hit) begin
      chk("reply latency in window", {31'b0, (n >= S + D && n <= S + D + 1)}, 1);
      if (!wr) begin
        chk("nAD_oe at reply", nAD_oe, 1);
        chk("nADo at reply", nADo, rv_n);
      end
      repeat (3) begin
        tick(1);
        if (!wr) chk("nADo stable while DIN low", nADo, rv_n);
      end
    end else begin
      chk("no reply for foreign address", nRPLYo, 1);
      chk("no nAD_oe for foreign address", any_oe, 0);
    end
    nDOUTi = 1'b1;
    nDINi = 1'b1;
    if (hit) begin
      n = 0;
      while (n < 10) begin
        tick(1);
        n++;
        if (nRPLYo) break;
      end
      chk("reply release latency", {31'b0, (n <= S + 1)}, 1);
      if (!wr) begin
        chk("nAD_oe held when reply drops", nAD_oe, 1);
        tick(1);
        chk("nAD_oe off one cycle later", nAD_oe, 0);
      end
    end
    tick(2);
    nSYNCi = 1'b1;
    nADi = '1;
    nWTBTi = 1'b1;
    tick(4);
    chk("port_out vs model", port_out, model);
  endtask

  task automatic odd_cycle(input bit abort);
    bit any_rply, any_oe;
    any_rply = 1'b0;
    any_oe = 1'b0;
    nADi = ~BASE;
    tick(2);
    nSYNCi = 1'b0;
    tick(4);
    nADi = abort ? ~16'hBEEF : 16'hFFFF;
    tick(1);
    nDOUTi = 1'b0;
    if (!abort) nDINi = 1'b0;
    tick(1);
    if (abort) nSYNCi = 1'b1;
    repeat (12) begin
      tick(1);
      any_rply |= ~nRPLYo;
      any_oe |= nAD_oe;
    end
    chk(abort ? "abort gives no reply" : "DIN+DOUT gives no reply", any_rply, 0);
    chk(abort ? "abort gives no nAD_oe" : "DIN+DOUT gives no nAD_oe", any_oe, 0);
    nDOUTi = 1'b1;
    nDINi = 1'b1;
    nSYNCi = 1'b1;
    nADi = '1;
    tick(4);
    chk("port_out unchanged", port_out, model);
  endtask

  initial begin
    bit any_rply;
    logic [15:0] a;
    bit wr, bw;
    tick(2);
    nADi = ~BASE;
    nSYNCi = 1'b0;
    tick(2);
    nDOUTi = 1'b0;
    nADi = ~16'h1111;
    tick(3);
    chk("reset port_out", port_out, 0);
    chk("reset nRPLYo", nRPLYo, 1);
    chk("reset nAD_oe", nAD_oe, 0);
    chk("reset nADo", nADo, 16'hFFFF);
    nRESETp = 1'b1;
    any_rply = 1'b0;
    repeat (12) begin
      tick(1);
      any_rply |= ~nRPLYo;
    end
    chk("no reply after reset mid-SYNC", any_rply, 0);
    nDOUTi = 1'b1;
    nSYNCi = 1'b1;
    nADi = '1;
    tick(4);
    xfer(1, 0, BASE, 16'h000F);
    xfer(1, 1, BASE | 16'd1, 16'h5500);
    xfer(1, 1, BASE, 16'h00AA);
    port_in = 16'h1234;
    xfer(0, 0, BASE, 16'h0000);
    xfer(0, 0, 16'o177716, 16'h0000);
    xfer(1, 0, 16'o177716, 16'hFFFF);
    odd_cycle(1);
    odd_cycle(0);
    xfer(1, 0, BASE | 16'd1, 16'hC3A5);
    repeat (40) begin
      case ($urandom_range(0, 3))
        0: a = BASE;
        1: a = BASE | 16'd1;
        2: a = 16'o177716 | 16'($urandom_range(0, 1));
        default: a = 16'($urandom);
      endcase
      wr = 1'($urandom);
      bw = wr & 1'($urandom);
      port_in = 16'($urandom);
      xfer(wr, bw, a, 16'($urandom));
    end
    tick(4);
    chk("scoreboard drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
